// File: rtl/mult_div_seq.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring) unit for HI/LO.
// Latency: 34 cycles from the start edge to the done pulse (32 iterations + FIX + DONE).
// Backpressure: none; a start is taken only in IDLE, and any start while busy is dropped.
//
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-low reset
//   start_mult        - request signed multiply (wins over start_div)
//   start_div         - request signed divide; b==0 gives div_zero instead
//   a, b              - operands, two's complement, sampled with the start
//   hi, lo            - MULT: product[2W-1:W] / product[W-1:0]; DIV: remainder / quotient
//   busy              - operation in progress (iterate + FIX cycles)
//   done              - one-cycle pulse, hi/lo freshly updated
//   div_zero          - one-cycle pulse, divide requested with b==0
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MULT,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Shared working registers.
  //   MULT: acc_hi = P_hi (one guard bit above WIDTH), acc_lo = P_lo, acc_q = q-1,
  //         opb = multiplicand.
  //   DIV:  acc_hi = partial remainder (borrow in the top bit), acc_lo = dividend
  //         shifting out / quotient shifting in, opb = |divisor|.
  // The guard bit on P_hi is needed because subtracting a multiplicand of -2^(W-1)
  // produces +2^(W-1), which does not fit in W signed bits.
  logic [WIDTH:0]   acc_hi, acc_hi_nxt;
  logic [WIDTH-1:0] acc_lo, acc_lo_nxt;
  logic             acc_q, acc_q_nxt;
  logic [WIDTH-1:0] opb, opb_nxt;
  logic             op_div, op_div_nxt;
  logic             neg_q, neg_q_nxt;
  logic             neg_r, neg_r_nxt;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic             div_zero_nxt;

  // Operand magnitudes; -2^(W-1) maps to 2^(W-1), which is exact as unsigned.
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // Booth step: add/subtract the sign-extended multiplicand per {q0, q-1}.
  logic [WIDTH:0] mcand_x;
  logic [WIDTH:0] booth_sum;
  assign mcand_x = {opb[WIDTH-1], opb};

  always_comb begin
    booth_sum = acc_hi;
    case ({acc_lo[0], acc_q})
      2'b01:   booth_sum = acc_hi + mcand_x;
      2'b10:   booth_sum = acc_hi - mcand_x;
      default: booth_sum = acc_hi;
    endcase
  end

  // Restoring division step: shift the next dividend bit into the remainder and
  // try subtracting the divisor; a set top bit of the difference means borrow.
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  assign div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};

  // Outputs are decodes of the registered state only.
  assign busy = (state == ST_MULT) || (state == ST_DIV) || (state == ST_FIX);
  assign done = (state == ST_DONE);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    acc_hi_nxt   = acc_hi;
    acc_lo_nxt   = acc_lo;
    acc_q_nxt    = acc_q;
    opb_nxt      = opb;
    op_div_nxt   = op_div;
    neg_q_nxt    = neg_q;
    neg_r_nxt    = neg_r;
    hi_nxt       = hi;
    lo_nxt       = lo;
    div_zero_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_mult) begin
          acc_hi_nxt = '0;
          acc_lo_nxt = b;
          acc_q_nxt  = 1'b0;
          opb_nxt    = a;
          op_div_nxt = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = ST_MULT;
        end else if (start_div) begin
          if (b == '0) begin
            // Rejected at the door: flag it and leave hi/lo untouched.
            div_zero_nxt = 1'b1;
          end else begin
            acc_hi_nxt = '0;
            acc_lo_nxt = a_mag;
            acc_q_nxt  = 1'b0;
            opb_nxt    = b_mag;
            op_div_nxt = 1'b1;
            neg_q_nxt  = a[WIDTH-1] ^ b[WIDTH-1];
            neg_r_nxt  = a[WIDTH-1];
            cnt_nxt    = '0;
            state_nxt  = ST_DIV;
          end
        end
      end

      ST_MULT: begin
        // Arithmetic right shift of {P_hi, P_lo, q-1} by one.
        acc_hi_nxt = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        acc_lo_nxt = {booth_sum[0], acc_lo[WIDTH-1:1]};
        acc_q_nxt  = acc_lo[0];
        cnt_nxt    = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = ST_FIX;
        end
      end

      ST_DIV: begin
        if (!div_diff[WIDTH]) begin
          acc_hi_nxt = div_diff;
          acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_nxt = div_shift;
          acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
        end
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = ST_FIX;
        end
      end

      ST_FIX: begin
        if (op_div) begin
          // Truncating division: quotient sign from the operand signs,
          // remainder sign follows the dividend. -2^(W-1)/-1 leaves the
          // unsigned quotient 2^(W-1) unnegated, i.e. 0x80..0.
          hi_nxt = neg_r ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
          lo_nxt = neg_q ? -acc_lo : acc_lo;
        end else begin
          hi_nxt = acc_hi[WIDTH-1:0];
          lo_nxt = acc_lo;
        end
        state_nxt = ST_DONE;
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      acc_q    <= 1'b0;
      opb      <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      acc_hi   <= acc_hi_nxt;
      acc_lo   <= acc_lo_nxt;
      acc_q    <= acc_q_nxt;
      opb      <= opb_nxt;
      op_div   <= op_div_nxt;
      neg_q    <= neg_q_nxt;
      neg_r    <= neg_r_nxt;
      hi       <= hi_nxt;
      lo       <= lo_nxt;
      div_zero <= div_zero_nxt;
    end
  end

endmodule
